// File: rtl/host_uart_rx_fifo_if.sv
// Receive-side bus of the host UART: FIFO head word, error flags, handshake and status.
// The receiver drives the master modport; the consumer uses the slave modport.
interface host_uart_rx_fifo_if #(
  parameter int DATA_BITS = 8,
  parameter int FIFO_AW   = 3
);
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_frame_err;
  logic                 rx_parity_err;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 overrun;
  logic                 clear_overrun;
  logic [FIFO_AW:0]     fifo_level;

  modport master (
    output rx_data, rx_frame_err, rx_parity_err, rx_valid, overrun, fifo_level,
    input  rx_ready, clear_overrun
  );

  modport slave (
    input  rx_data, rx_frame_err, rx_parity_err, rx_valid, overrun, fifo_level,
    output rx_ready, clear_overrun
  );
endinterface

// File: rtl/host_uart_rx_fifo.sv
// Parametrised async serial receiver with synchronised, edge-qualified input and a
// first-word-fall-through FIFO holding {parity_err, frame_err, data} per received word.
module host_uart_rx_fifo #(
  parameter int CLKFREQ   = 100,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int FIFO_AW   = 3
) (
  input  logic                 clk,
  input  logic                 n_reset,
  input  logic                 ser_in_i,
  host_uart_rx_fifo_if.master  rx_if
);

  localparam int TPB   = (CLKFREQ * 1000000) / BAUD;
  localparam int CW    = $clog2(TPB + 1);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int WW    = DATA_BITS + 2;

  localparam logic [CW-1:0]      HALF_LD   = CW'(TPB / 2 - 1);
  localparam logic [CW-1:0]      FULL_LD   = CW'(TPB - 1);
  localparam logic [CW-1:0]      CNT_ONE   = CW'(1);
  localparam logic [2:0]         DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0]         STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1);
  localparam logic [FIFO_AW:0]   LVL_ONE   = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW:0]   FULL_LVL  = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  state_t                 state_q, state_d;
  logic                   sync1_q, line_q, line_dly_q;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [2:0]             bit_q, bit_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   ferr_q, ferr_d;
  logic                   perr_q, perr_d;
  logic                   push_q, push_d;
  logic                   tick;

  logic [WW-1:0]          mem [DEPTH];
  logic [FIFO_AW-1:0]     wr_q, wr_d, rd_q, rd_d;
  logic [FIFO_AW:0]       level_q, level_d;
  logic                   overrun_q, overrun_d;
  logic                   empty, full, pop, wr_en, drop;
  logic [WW-1:0]          head;

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      sync1_q    <= 1'b1;
      line_q     <= 1'b1;
      line_dly_q <= 1'b1;
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      ferr_q     <= 1'b0;
      perr_q     <= 1'b0;
      push_q     <= 1'b0;
      wr_q       <= '0;
      rd_q       <= '0;
      level_q    <= '0;
      overrun_q  <= 1'b0;
    end else begin
      sync1_q    <= ser_in_i;
      line_q     <= sync1_q;
      line_dly_q <= line_q;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      ferr_q     <= ferr_d;
      perr_q     <= perr_d;
      push_q     <= push_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      level_q    <= level_d;
      overrun_q  <= overrun_d;
    end
  end

  // Datapath storage carries no reset; outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
    if (wr_en) mem[wr_q] <= {perr_q, ferr_q, shift_q};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    ferr_d  = ferr_q;
    perr_d  = perr_q;
    push_d  = 1'b0;
    tick    = (cnt_q == '0);
    if (state_q != S_IDLE) cnt_d = tick ? FULL_LD : cnt_q - CNT_ONE;
    unique case (state_q)
      S_IDLE: begin
        // Only a real high-to-low transition arms the receiver, never a held-low line.
        if (line_dly_q && !line_q) begin
          state_d = S_START;
          cnt_d   = HALF_LD;
          ferr_d  = 1'b0;
          perr_d  = 1'b0;
        end
      end
      S_START: begin
        if (tick) begin
          if (line_q) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            bit_d   = '0;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          shift_d = {line_q, shift_q[DATA_BITS-1:1]};
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? S_PAR : S_STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      S_PAR: begin
        if (tick) begin
          perr_d  = (PARITY == 2) ? (^shift_q ^ line_q) : ~(^shift_q ^ line_q);
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (tick) begin
          if (!line_q) ferr_d = 1'b1;
          if (bit_q == STOP_LAST) begin
            state_d = S_IDLE;
            push_d  = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    empty   = (level_q == '0);
    full    = (level_q == FULL_LVL);
    pop     = !empty && rx_if.rx_ready;
    wr_en   = push_q && (!full || pop);
    drop    = push_q && full && !pop;
    wr_d    = wr_en ? wr_q + PTR_ONE : wr_q;
    rd_d    = pop ? rd_q + PTR_ONE : rd_q;
    level_d = level_q;
    if (wr_en && !pop)      level_d = level_q + LVL_ONE;
    else if (pop && !wr_en) level_d = level_q - LVL_ONE;
    // A fresh drop outranks a same-cycle clear so no loss goes unreported.
    overrun_d = drop ? 1'b1 : (rx_if.clear_overrun ? 1'b0 : overrun_q);
    head      = empty ? '0 : mem[rd_q];
  end

  assign rx_if.rx_data       = head[DATA_BITS-1:0];
  assign rx_if.rx_frame_err  = head[DATA_BITS];
  assign rx_if.rx_parity_err = head[DATA_BITS+1];
  assign rx_if.rx_valid      = !empty;
  assign rx_if.overrun       = overrun_q;
  assign rx_if.fifo_level    = level_q;

endmodule

// File: tb/tb_host_uart_rx_fifo.sv
// Directed plus randomized bench for host_uart_rx_fifo across five configurations
// (8N1, even parity, odd parity, 4-deep FIFO, 5-bit with two stop bits).
module tb_host_uart_rx_fifo;

  localparam int TPB = 10;

  logic clk = 1'b0;
  logic n_reset = 1'b0;
  logic ser [5];
  logic rdy [5];
  logic clr [5];
  logic [7:0] hd [5];
  logic [3:0] lvl [5];
  logic fe [5], pe [5], vld [5], ovr [5];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  host_uart_rx_fifo_if #(.DATA_BITS(8), .FIFO_AW(3)) if0 ();
  host_uart_rx_fifo_if #(.DATA_BITS(8), .FIFO_AW(3)) if1 ();
  host_uart_rx_fifo_if #(.DATA_BITS(8), .FIFO_AW(3)) if2 ();
  host_uart_rx_fifo_if #(.DATA_BITS(8), .FIFO_AW(2)) if3 ();
  host_uart_rx_fifo_if #(.DATA_BITS(5), .FIFO_AW(3)) if4 ();

  host_uart_rx_fifo #(.CLKFREQ(10), .BAUD(1000000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_AW(3))
    dut0 (.clk(clk), .n_reset(n_reset), .ser_in_i(ser[0]), .rx_if(if0));
  host_uart_rx_fifo #(.CLKFREQ(10), .BAUD(1000000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_AW(3))
    dut1 (.clk(clk), .n_reset(n_reset), .ser_in_i(ser[1]), .rx_if(if1));
  host_uart_rx_fifo #(.CLKFREQ(10), .BAUD(1000000), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_AW(3))
    dut2 (.clk(clk), .n_reset(n_reset), .ser_in_i(ser[2]), .rx_if(if2));
  host_uart_rx_fifo #(.CLKFREQ(10), .BAUD(1000000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_AW(2))
    dut3 (.clk(clk), .n_reset(n_reset), .ser_in_i(ser[3]), .rx_if(if3));
  host_uart_rx_fifo #(.CLKFREQ(10), .BAUD(1000000), .DATA_BITS(5), .PARITY(0), .STOP_BITS(2), .FIFO_AW(3))
    dut4 (.clk(clk), .n_reset(n_reset), .ser_in_i(ser[4]), .rx_if(if4));

  assign if0.rx_ready = rdy[0];  assign if0.clear_overrun = clr[0];
  assign if1.rx_ready = rdy[1];  assign if1.clear_overrun = clr[1];
  assign if2.rx_ready = rdy[2];  assign if2.clear_overrun = clr[2];
  assign if3.rx_ready = rdy[3];  assign if3.clear_overrun = clr[3];
  assign if4.rx_ready = rdy[4];  assign if4.clear_overrun = clr[4];

  assign hd[0] = if0.rx_data;  assign lvl[0] = if0.fifo_level;
  assign hd[1] = if1.rx_data;  assign lvl[1] = if1.fifo_level;
  assign hd[2] = if2.rx_data;  assign lvl[2] = if2.fifo_level;
  assign hd[3] = if3.rx_data;  assign lvl[3] = {1'b0, if3.fifo_level};
  assign hd[4] = {3'b000, if4.rx_data};  assign lvl[4] = if4.fifo_level;

  assign fe[0] = if0.rx_frame_err;  assign pe[0] = if0.rx_parity_err;
  assign fe[1] = if1.rx_frame_err;  assign pe[1] = if1.rx_parity_err;
  assign fe[2] = if2.rx_frame_err;  assign pe[2] = if2.rx_parity_err;
  assign fe[3] = if3.rx_frame_err;  assign pe[3] = if3.rx_parity_err;
  assign fe[4] = if4.rx_frame_err;  assign pe[4] = if4.rx_parity_err;

  assign vld[0] = if0.rx_valid;  assign ovr[0] = if0.overrun;
  assign vld[1] = if1.rx_valid;  assign ovr[1] = if1.overrun;
  assign vld[2] = if2.rx_valid;  assign ovr[2] = if2.overrun;
  assign vld[3] = if3.rx_valid;  assign ovr[3] = if3.overrun;
  assign vld[4] = if4.rx_valid;  assign ovr[4] = if4.overrun;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Serialise one frame: start, data LSB first, optional parity, one or two stop bits.
  task automatic send(input int k, input logic [7:0] d, input int dbits, input bit has_par,
                      input logic p, input logic s1, input logic s2, input int nstop);
    logic [11:0] b;
    int n;
    b = '0;
    n = 0;
    b[n] = 1'b0; n++;
    for (int i = 0; i < dbits; i++) begin b[n] = d[i]; n++; end
    if (has_par) begin b[n] = p; n++; end
    b[n] = s1; n++;
    if (nstop == 2) begin b[n] = s2; n++; end
    for (int i = 0; i < n; i++) begin
      ser[k] = b[i];
      repeat (TPB) @(negedge clk);
    end
  endtask

  task automatic send8(input int k, input logic [7:0] d);
    send(k, d, 8, 1'b0, 1'b0, 1'b1, 1'b1, 1);
  endtask

  task automatic pop_chk(input int k, input string tag, input int ed, input int efe, input int epe);
    chk({tag, ".vld"}, 32'(vld[k]), 1);
    chk({tag, ".data"}, 32'(hd[k]), ed);
    chk({tag, ".ferr"}, 32'(fe[k]), efe);
    chk({tag, ".perr"}, 32'(pe[k]), epe);
    rdy[k] = 1'b1;
    @(negedge clk);
    rdy[k] = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired before the end of the sequence");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] qd[$];
    logic       qp[$];
    logic [7:0] d;
    logic       p;

    for (int k = 0; k < 5; k++) begin ser[k] = 1'b1; rdy[k] = 1'b0; clr[k] = 1'b0; end
    n_reset = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      chk("rst.vld", 32'(vld[k]), 0);
      chk("rst.lvl", 32'(lvl[k]), 0);
      chk("rst.ovr", 32'(ovr[k]), 0);
      chk("rst.data", 32'(hd[k]), 0);
      chk("rst.flags", {30'd0, pe[k], fe[k]}, 0);
    end
    n_reset = 1'b1;
    repeat (3) @(negedge clk);

    // 8N1 word and rx_valid latency relative to the stop-bit mid-sample
    fork
      send8(0, 8'hA5);
      begin
        repeat (98) @(negedge clk);
        chk("t1.vld_before", 32'(vld[0]), 0);
        @(negedge clk);
        chk("t1.vld_rise", 32'(vld[0]), 1);
      end
    join
    chk("t1.lvl", 32'(lvl[0]), 1);
    pop_chk(0, "t1.pop", 8'hA5, 0, 0);
    chk("t1.lvl_after", 32'(lvl[0]), 0);

    // Even and odd parity with the parity bit forced both ways
    send(1, 8'h03, 8, 1'b1, 1'b1, 1'b1, 1'b1, 1);
    send(1, 8'h03, 8, 1'b1, 1'b0, 1'b1, 1'b1, 1);
    send(2, 8'h03, 8, 1'b1, 1'b1, 1'b1, 1'b1, 1);
    send(2, 8'h03, 8, 1'b1, 1'b0, 1'b1, 1'b1, 1);
    pop_chk(1, "t2.even_p1", 8'h03, 0, 1);
    pop_chk(1, "t2.even_p0", 8'h03, 0, 0);
    pop_chk(2, "t2.odd_p1", 8'h03, 0, 0);
    pop_chk(2, "t2.odd_p0", 8'h03, 0, 1);

    // Random words and parity bits on the even-parity receiver
    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom);
      p = 1'($urandom_range(0, 1));
      qd.push_back(d);
      qp.push_back((($countones(d) + int'(p)) % 2) == 1);
      send(1, d, 8, 1'b1, p, 1'b1, 1'b1, 1);
      repeat ($urandom_range(0, 4)) @(negedge clk);
    end
    chk("rnd_par.lvl", 32'(lvl[1]), 6);
    while (qd.size() > 0) begin
      d = qd.pop_front();
      p = qp.pop_front();
      pop_chk(1, "rnd_par", d, 0, int'(p));
    end

    // Stop bit low followed by a long break: one errored word, then no re-arm until high
    send(0, 8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1);
    repeat (30 * TPB) @(negedge clk);
    chk("t3.lvl_break", 32'(lvl[0]), 1);
    pop_chk(0, "t3.break", 8'h55, 1, 0);
    ser[0] = 1'b1;
    repeat (TPB) @(negedge clk);
    send8(0, 8'h3C);
    pop_chk(0, "t3.recover", 8'h3C, 0, 0);

    // Short glitch is a false start; a real frame right after still decodes
    ser[0] = 1'b0; repeat (3) @(negedge clk);
    ser[0] = 1'b1; repeat (120) @(negedge clk);
    chk("t5.glitch_lvl", 32'(lvl[0]), 0);
    ser[0] = 1'b0; repeat (3) @(negedge clk);
    ser[0] = 1'b1; repeat (7) @(negedge clk);
    send8(0, 8'h96);
    chk("t5.lvl", 32'(lvl[0]), 1);
    pop_chk(0, "t5.after_glitch", 8'h96, 0, 0);

    // Overflow of the 4-deep FIFO, clear, and drop coinciding with clear
    for (int i = 1; i <= 5; i++) send8(3, 8'(i));
    chk("t4.lvl_full", 32'(lvl[3]), 4);
    chk("t4.ovr_set", 32'(ovr[3]), 1);
    for (int i = 1; i <= 4; i++) pop_chk(3, "t4.pop", i, 0, 0);
    chk("t4.lvl_empty", 32'(lvl[3]), 0);
    clr[3] = 1'b1; @(negedge clk); clr[3] = 1'b0;
    chk("t4.ovr_clr", 32'(ovr[3]), 0);
    for (int i = 6; i <= 9; i++) send8(3, 8'(i));
    chk("t4.ovr_refill", 32'(ovr[3]), 0);
    fork
      send8(3, 8'hAA);
      begin
        repeat (98) @(negedge clk);
        clr[3] = 1'b1;
        @(negedge clk);
        clr[3] = 1'b0;
      end
    join
    chk("t4.ovr_set_wins", 32'(ovr[3]), 1);
    chk("t4.lvl_kept", 32'(lvl[3]), 4);
    chk("t4.head_kept", 32'(hd[3]), 6);

    // Random bytes with random idle gaps against a queue of sent words
    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom);
      qd.push_back(d);
      send8(0, d);
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end
    chk("rnd.lvl", 32'(lvl[0]), 8);
    chk("rnd.ovr", 32'(ovr[0]), 0);
    while (qd.size() > 0) begin
      d = qd.pop_front();
      pop_chk(0, "rnd", d, 0, 0);
    end

    // 5-bit, two stop bits: back-to-back frames, second stop bit low, reset mid-frame
    send(4, 8'h1F, 5, 1'b0, 1'b0, 1'b1, 1'b1, 2);
    send(4, 8'h00, 5, 1'b0, 1'b0, 1'b1, 1'b1, 2);
    chk("t6.lvl_b2b", 32'(lvl[4]), 2);
    pop_chk(4, "t6.b2b_a", 8'h1F, 0, 0);
    pop_chk(4, "t6.b2b_b", 8'h00, 0, 0);
    send(4, 8'h0A, 5, 1'b0, 1'b0, 1'b1, 1'b0, 2);
    ser[4] = 1'b1;
    repeat (TPB) @(negedge clk);
    pop_chk(4, "t6.stop2_low", 8'h0A, 1, 0);
    send(4, 8'h15, 5, 1'b0, 1'b0, 1'b1, 1'b1, 2);
    chk("t6.lvl_pre_rst", 32'(lvl[4]), 1);
    ser[4] = 1'b0; repeat (TPB) @(negedge clk);
    ser[4] = 1'b1; repeat (2 * TPB) @(negedge clk);
    n_reset = 1'b0;
    repeat (2) @(negedge clk);
    n_reset = 1'b1;
    repeat (150) @(negedge clk);
    chk("t6.rst_lvl", 32'(lvl[4]), 0);
    chk("t6.rst_vld", 32'(vld[4]), 0);
    send(4, 8'h0B, 5, 1'b0, 1'b0, 1'b1, 1'b1, 2);
    pop_chk(4, "t6.post_rst", 8'h0B, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/host_uart_rx_fifo.md
Name: host_uart_rx_fifo

Overview:
Parametrised asynchronous serial receiver for the host/IO-controller link, the successor to the fixed 8N1 115200 console receiver. Supports configurable baud, word length, parity and stop bits, and a synchronised, edge-qualified input. Reports framing and parity errors and buffers received words in a first-word-fall-through FIFO with a valid/ready interface, replacing the single-cycle strobe.

Parameters:
CLKFREQ, 100, system clock in MHz
BAUD, 115200, line rate in bit/s
DATA_BITS, 8, word length, legal 5..8
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, legal 1 or 2
FIFO_AW, 3, FIFO depth = 2**FIFO_AW words

Ports:
clk  in  1  system clock
n_reset  in  1  reset, synchronous, active-low
ser_in  in  1  asynchronous serial line, idle high
rx_data  out  DATA_BITS  FIFO head word, LSB = first received bit
rx_frame_err  out  1  head word had a stop bit sampled 0
rx_parity_err  out  1  head word failed parity (always 0 when PARITY = 0)
rx_valid  out  1  FIFO not empty
rx_ready  in  1  consumer pops the head when rx_valid && rx_ready
overrun  out  1  sticky: a word was dropped because the FIFO was full
clear_overrun  in  1  clears overrun
fifo_level  out  FIFO_AW+1  number of words held

Behaviour:
- Reset (n_reset low at a clk edge): FSM in IDLE; FIFO empty; rx_valid, overrun, fifo_level, rx_data, rx_frame_err and rx_parity_err all 0; synchroniser flops and edge register set to 1.
- TPB = (CLKFREQ*1000000)/BAUD, integer truncation. ser_in passes through a 2-flop synchroniser; "line" means the second flop. A 1-cycle delayed copy, line_d, is used for edge detection.
- IDLE: start is detected when line_d = 1 and line = 0 (falling edge). A level-low line never triggers, so after a break the line must return high before re-arming. On start: load tick counter with TPB/2 - 1 and go to START.
- Tick counter decrements every cycle. A sample is taken when it reaches 0, then it reloads with TPB - 1.
- START: at the sample, line = 1 means a false start; return to IDLE and push nothing. Otherwise go to DATA with bit index 0.
- DATA: DATA_BITS samples, shifted in LSB first. Go to PARITY if PARITY != 0, else STOP.
- PARITY: one sample. Parity error for even mode is XOR(data, p) = 1; for odd mode it is XOR(data, p) = 0.
- STOP: STOP_BITS samples. Frame error if any stop sample is 0. After the last stop sample the FSM goes straight to IDLE; the mid-stop-bit slack permits back-to-back frames.
- The push occurs on the cycle after the last stop sample and writes {parity_err, frame_err, data}. Errored words are still pushed. rx_valid rises on the cycle after the push (2 clk after the final stop sample).
- FIFO:
  - Pop when rx_valid && rx_ready; the head advances at that edge.
  - Push while full is accepted only if a pop occurs in the same cycle. Otherwise the word is dropped, the FIFO is unchanged and overrun is set.
  - Simultaneous push and pop leaves fifo_level unchanged.
  - Pointers wrap modulo 2**FIFO_AW; full = (level == 2**FIFO_AW).
  - rx_ready with rx_valid = 0 is ignored.
- overrun: clear_overrun clears it. If a new drop coincides with clear_overrun, set wins.
- Reset mid-frame abandons the partial word; no push.

Test Plan:
All scenarios use CLKFREQ=10, BAUD=1000000, so TPB=10.
1. 8N1 with rx_ready=0: send 0xA5 -> one push; rx_data=0xA5, rx_valid=1, no error flags, fifo_level=1. rx_valid rises 2 clk after the stop mid-sample.
2. PARITY=2: send 0x03 with parity bit 1 -> rx_parity_err=1 and data 0x03. Send 0x03 with parity bit 0 -> rx_parity_err=0. With PARITY=1 the same two frames give the inverse flags.
3. Stop bit driven 0, then line held low for 30 bit times -> one word with rx_frame_err=1. No further pushes until the line returns high, then a new frame decodes correctly.
4. FIFO_AW=2, rx_ready=0: send 5 frames 0x01..0x05 -> fifo_level=4, overrun=1, pops return 0x01..0x04. Pulse clear_overrun -> overrun=0. A drop coinciding with clear_overrun leaves overrun=1.
5. Glitch: line low for 3 clk -> false start, no push, FSM returns to IDLE. A frame sent immediately after decodes correctly.
6. STOP_BITS=2, DATA_BITS=5: back-to-back frames 0x1F, 0x00 -> both received. Second stop bit forced 0 -> rx_frame_err=1. Assert n_reset mid-frame -> fifo_level=0, no push.
